// File: rtl/bram_dp_r2w1.sv
// Simple dual-port block RAM: one synchronous write port, two independent
// registered read ports (read-first), plus a combinational debug view of the array.
module bram_dp_r2w1 #(
  parameter  int DTW = 32,
  parameter  int DPT = 32,
  localparam int AW  = $clog2(DPT)
) (
  input  logic           clk,
  input  logic           areset,
  input  logic           i_wren,
  input  logic [AW-1:0]  i_waddr,
  input  logic [DTW-1:0] i_wdata,
  output logic [DTW-1:0] o_marray [0:DPT-1],
  input  logic           i_rden0,
  input  logic [AW-1:0]  i_raddr0,
  output logic [DTW-1:0] o_rdata0,
  input  logic           i_rden1,
  input  logic [AW-1:0]  i_raddr1,
  output logic [DTW-1:0] o_rdata1
);

  // Array is never reset so the tools can map it onto block RAM; the
  // declaration initialiser becomes the bitstream init contents.
  logic [DTW-1:0] mem [0:DPT-1] = '{default: '0};

  logic          waddr_ok;
  logic          wr_en;
  logic          rden_v  [2];
  logic [AW-1:0] raddr_v [2];

  assign rden_v[0]  = i_rden0;
  assign rden_v[1]  = i_rden1;
  assign raddr_v[0] = i_raddr0;
  assign raddr_v[1] = i_raddr1;

  // Range checks only exist when the depth leaves unused addresses.
  generate
    if (DPT == (1 << AW)) begin : g_wfull
      assign waddr_ok = 1'b1;
    end else begin : g_wpart
      assign waddr_ok = ({1'b0, i_waddr} < (AW+1)'(DPT));
    end
  endgenerate

  assign wr_en = i_wren & waddr_ok & ~areset;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : rd_port
      logic           raddr_ok;
      logic [DTW-1:0] rdata_reg;

      if (DPT == (1 << AW)) begin : g_rfull
        assign raddr_ok = 1'b1;
      end else begin : g_rpart
        assign raddr_ok = ({1'b0, raddr_v[gi]} < (AW+1)'(DPT));
      end

      // Non-blocking read of mem gives read-first behaviour against a same-edge write.
      always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
          rdata_reg <= '0;
        end else if (rden_v[gi]) begin
          rdata_reg <= raddr_ok ? mem[raddr_v[gi]] : '0;
        end
      end
    end

    for (genvar gi = 0; gi < DPT; gi++) begin : g_dbg
      assign o_marray[gi] = mem[gi];
    end
  endgenerate

  assign o_rdata0 = rd_port[0].rdata_reg;
  assign o_rdata1 = rd_port[1].rdata_reg;

endmodule

// File: tb/tb_bram_dp_r2w1.sv
// Directed and randomized checks of bram_dp_r2w1 against hand-computed
// values and a read-first reference model.
module tb_bram_dp_r2w1;

  localparam int DTW = 32;
  localparam int DPT = 32;
  localparam int AW  = 5;

  logic           clk = 1'b0;
  logic           areset;
  logic           wren;
  logic [AW-1:0]  waddr;
  logic [DTW-1:0] wdata;
  logic [DTW-1:0] marray [0:DPT-1];
  logic           rden0, rden1;
  logic [AW-1:0]  raddr0, raddr1;
  logic [DTW-1:0] rdata0, rdata1;

  int n_cmp = 0;
  int n_bad = 0;

  bram_dp_r2w1 #(.DTW(DTW), .DPT(DPT)) dut (
    .clk      (clk),
    .areset   (areset),
    .i_wren   (wren),
    .i_waddr  (waddr),
    .i_wdata  (wdata),
    .o_marray (marray),
    .i_rden0  (rden0),
    .i_raddr0 (raddr0),
    .o_rdata0 (rdata0),
    .i_rden1  (rden1),
    .i_raddr1 (raddr1),
    .o_rdata1 (rdata1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wren = 1'b0; waddr = '0; wdata = '0;
    rden0 = 1'b0; raddr0 = '0;
    rden1 = 1'b0; raddr1 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    areset = 1'b1;
    // a write attempted under reset must be dropped
    wren = 1'b1; waddr = 5'd3; wdata = 32'hFFFF_FFFF;
    tick(); tick();
    wren = 1'b0;
    areset = 1'b0;
    tick();
    n_cmp++;
    if (rdata0 !== 32'h0) begin n_bad++; $display("FAIL reset_rdata0: got %h expected %h", rdata0, 32'h0); end
    n_cmp++;
    if (rdata1 !== 32'h0) begin n_bad++; $display("FAIL reset_rdata1: got %h expected %h", rdata1, 32'h0); end
    for (int i = 0; i < DPT; i++) begin
      n_cmp++;
      if (marray[i] !== 32'h0) begin n_bad++; $display("FAIL reset_marray[%0d]: got %h expected %h", i, marray[i], 32'h0); end
    end
    $display("test_reset: outputs and array checked after reset");
  endtask

  task automatic test_write_read();
    wren = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; tick();
    n_cmp++;
    if (marray[5] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_marray5: got %h expected %h", marray[5], 32'hDEAD_BEEF); end
    waddr = 5'd31; wdata = 32'h1234_5678; tick();
    wren = 1'b0;
    rden0 = 1'b1; raddr0 = 5'd5;
    rden1 = 1'b1; raddr1 = 5'd31;
    tick();
    n_cmp++;
    if (rdata0 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_rd_port0: got %h expected %h", rdata0, 32'hDEAD_BEEF); end
    n_cmp++;
    if (rdata1 !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_rd_port1: got %h expected %h", rdata1, 32'h1234_5678); end
    $display("test_write_read: rdata0=%h rdata1=%h", rdata0, rdata1);
  endtask

  task automatic test_rden_hold();
    rden0 = 1'b0; raddr0 = 5'd31; rden1 = 1'b0;
    wren = 1'b1; waddr = 5'd5; wdata = 32'h0;
    tick();
    wren = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rdata0 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL hold_port0: got %h expected %h", rdata0, 32'hDEAD_BEEF); end
      tick();
    end
    n_cmp++;
    if (marray[5] !== 32'h0) begin n_bad++; $display("FAIL hold_marray5: got %h expected %h", marray[5], 32'h0); end
    rden0 = 1'b1;
    tick();
    rden0 = 1'b0;
    n_cmp++;
    if (rdata0 !== 32'h1234_5678) begin n_bad++; $display("FAIL hold_reread: got %h expected %h", rdata0, 32'h1234_5678); end
    $display("test_rden_hold: rdata0=%h after re-enable", rdata0);
  endtask

  task automatic test_rdw();
    wren = 1'b1; waddr = 5'd7; wdata = 32'hAAAA_0000; tick();
    wdata = 32'h5555_FFFF;
    rden0 = 1'b1; raddr0 = 5'd7;
    rden1 = 1'b1; raddr1 = 5'd7;
    tick();
    wren = 1'b0;
    n_cmp++;
    if (rdata0 !== 32'hAAAA_0000) begin n_bad++; $display("FAIL rdw_old_port0: got %h expected %h", rdata0, 32'hAAAA_0000); end
    n_cmp++;
    if (rdata1 !== 32'hAAAA_0000) begin n_bad++; $display("FAIL rdw_old_port1: got %h expected %h", rdata1, 32'hAAAA_0000); end
    tick();
    n_cmp++;
    if (rdata0 !== 32'h5555_FFFF) begin n_bad++; $display("FAIL rdw_new_port0: got %h expected %h", rdata0, 32'h5555_FFFF); end
    n_cmp++;
    if (rdata1 !== 32'h5555_FFFF) begin n_bad++; $display("FAIL rdw_new_port1: got %h expected %h", rdata1, 32'h5555_FFFF); end
    rden0 = 1'b0; rden1 = 1'b0;
    $display("test_rdw: old then new value on both ports");
  endtask

  task automatic test_async_reset();
    rden0 = 1'b1; raddr0 = 5'd31;
    rden1 = 1'b1; raddr1 = 5'd7;
    tick(); tick();
    n_cmp++;
    if (rdata0 !== 32'h1234_5678) begin n_bad++; $display("FAIL ar_pre_port0: got %h expected %h", rdata0, 32'h1234_5678); end
    #2 areset = 1'b1;
    #1;
    n_cmp++;
    if (rdata0 !== 32'h0) begin n_bad++; $display("FAIL ar_async_port0: got %h expected %h", rdata0, 32'h0); end
    n_cmp++;
    if (rdata1 !== 32'h0) begin n_bad++; $display("FAIL ar_async_port1: got %h expected %h", rdata1, 32'h0); end
    rden0 = 1'b0; rden1 = 1'b0;
    wren = 1'b1; waddr = 5'd31; wdata = 32'h0;
    tick();
    wren = 1'b0;
    areset = 1'b0;
    tick();
    n_cmp++;
    if (rdata0 !== 32'h0) begin n_bad++; $display("FAIL ar_post_port0: got %h expected %h", rdata0, 32'h0); end
    rden0 = 1'b1; raddr0 = 5'd31;
    tick();
    rden0 = 1'b0;
    n_cmp++;
    if (rdata0 !== 32'h1234_5678) begin n_bad++; $display("FAIL ar_reread31: got %h expected %h", rdata0, 32'h1234_5678); end
    $display("test_async_reset: rdata0=%h after reread of addr 31", rdata0);
  endtask

  task automatic test_random();
    logic [DTW-1:0] model [0:DPT-1];
    logic [DTW-1:0] exp0, exp1;
    int prints = 0;
    idle_inputs();
    wren = 1'b1;
    for (int a = 0; a < DPT; a++) begin
      waddr = AW'(a); wdata = $urandom; model[a] = wdata;
      tick();
    end
    wren = 1'b0;
    #2 areset = 1'b1;
    tick();
    areset = 1'b0;
    exp0 = '0; exp1 = '0;
    for (int c = 0; c < 10000; c++) begin
      wren   = 1'($urandom_range(0, 1));
      waddr  = AW'($urandom_range(0, DPT - 1));
      wdata  = $urandom;
      rden0  = 1'($urandom_range(0, 1));
      raddr0 = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, DPT - 1));
      rden1  = 1'($urandom_range(0, 1));
      raddr1 = ($urandom_range(0, 2) == 0) ? raddr0 : AW'($urandom_range(0, DPT - 1));
      tick();
      if (rden0) exp0 = model[raddr0];
      if (rden1) exp1 = model[raddr1];
      if (wren) model[waddr] = wdata;
      n_cmp++;
      if (rdata0 !== exp0) begin
        n_bad++;
        if (prints < 20) begin prints++; $display("FAIL rand_port0 cyc %0d: got %h expected %h", c, rdata0, exp0); end
      end
      n_cmp++;
      if (rdata1 !== exp1) begin
        n_bad++;
        if (prints < 20) begin prints++; $display("FAIL rand_port1 cyc %0d: got %h expected %h", c, rdata1, exp1); end
      end
    end
    idle_inputs();
    for (int a = 0; a < DPT; a++) begin
      n_cmp++;
      if (marray[a] !== model[a]) begin n_bad++; $display("FAIL rand_marray[%0d]: got %h expected %h", a, marray[a], model[a]); end
    end
    $display("test_random: 10000 cycles done");
  endtask

  initial begin
    areset = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_rden_hold();
    test_rdw();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
